change_dispenser: RTL
=====================

Name: change_dispenser

Overview:
- Sequences payout of the change amount produced by the vending FSM through a single coin hopper.
- Ejects one coin per handshake, choosing denominations greedily (10, 5, 1).
- Tracks per-denomination coin inventory and accepts refills.
- Flags a shortfall when the inventory cannot cover the requested change.

Parameters:
- WIDTH, 32: width of change amount and remaining counter.
- INV_W, 8: width of each inventory counter.
- INIT_10, 8: inventory of 10-dollar coins after reset.
- INIT_5, 8: inventory of 5-dollar coins after reset.
- INIT_1, 8: inventory of 1-dollar coins after reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- change_in  input  WIDTH  change amount to pay out; sampled when change_valid=1.
- change_valid  input  1  request strobe; accepted only in IDLE.
- coin_ack  input  1  hopper has ejected the presented coin.
- refill  input  1  refill strobe; accepted only in IDLE.
- refill_denom  input  2  denomination to refill: 0=1-dollar, 1=5-dollar, 2=10-dollar, 3=ignored.
- refill_count  input  INV_W  number of coins added.
- coin_out  output  WIDTH  denomination presented to hopper: 10, 5, 1, or 0 when idle.
- coin_valid  output  1  coin_out is valid; held until acknowledged.
- busy  output  1  payout in progress.
- done  output  1  one-cycle pulse at payout end.
- short  output  1  payout ended with nonzero remaining.
- remaining  output  WIDTH  amount still owed.

Behaviour:
- Reset (reset=0 at an edge), regardless of current state:
  - State returns to IDLE.
  - coin_out=0, coin_valid=0, busy=0, done=0, short=0, remaining=0.
  - Inventories load INIT_10, INIT_5, INIT_1.
  - Reset in EJECT drops coin_valid at that edge; no inventory decrement for the pending coin.
- States: IDLE, SELECT, EJECT, DONE.
- IDLE:
  - On change_valid=1: remaining<=change_in, short<=0, busy<=1, next SELECT.
  - change_in=0 is still accepted; SELECT then goes straight to DONE.
- SELECT (one cycle):
  - If remaining=0: next DONE.
  - Else pick the largest denomination d with d<=remaining and inventory(d)>0: coin_out<=d, coin_valid<=1, next EJECT.
  - If no denomination qualifies: short<=1, next DONE.
- EJECT:
  - coin_out and coin_valid are held stable until coin_ack=1 is sampled.
  - On that edge: remaining<=remaining-coin_out; inventory(coin_out) decrements by 1; coin_valid<=0; coin_out<=0; next SELECT.
  - coin_ack while not in EJECT is ignored.
- DONE (one cycle):
  - done=1, busy<=0, next IDLE.
  - remaining and short hold until the next accepted request or reset.
- Latency with immediate ack:
  - Request edge to first coin_valid: 2 cycles.
  - Each further coin: 2 cycles.
  - Last ack to done: 2 cycles.
- change_valid and refill while busy are dropped; the request is not queued.
- Refill in IDLE: inventory(refill_denom) += refill_count, saturating at 2^INV_W-1.
- Refill and change_valid in the same IDLE cycle: both accepted. SELECT sees the refilled inventory.
- Arithmetic: remaining never underflows, because d<=remaining is guaranteed. Inventory never goes below 0.

Test Plan:
- Default inventory; change_valid with change_in=6 at cycle 0; ack tied high -> coin_valid with coin_out=5 at cycle 2; coin_out=1 at cycle 4; done=1 at cycle 6; remaining=0; short=0; inv5=7, inv1=7.
- change_in=26; ack high -> coin sequence 10, 10, 5, 1; done pulses once; busy high from cycle 1 through the DONE cycle.
- Refill denom 2 with count 0 is a no-op; reset with INIT_10=1; change_in=30 -> sequence 10, 5, 5, 5, 5; inv10=0, inv5=4.
- Inventory inv10=0, inv5=0, inv1=3; change_in=5 -> three 1-dollar coins, then done with short=1, remaining=2; next request clears short.
- coin_ack delayed 3 cycles in EJECT -> coin_out and coin_valid stable for 4 cycles; change_valid pulsed during EJECT is ignored; exactly one decrement per ack.
- reset=0 asserted in EJECT -> next edge coin_valid=0, busy=0, remaining=0, inventories at INIT values; a refill of 250 onto inv1=8 saturates at 255.

Source files
------------

// File: rtl/change_dispenser.sv
// Greedy (10/5/1) change payout through a single coin hopper, with per-denomination inventory and refill.
// Two cycles request-to-first-coin; coin_out/coin_valid hold until coin_ack; requests and refills while busy are dropped.
module change_dispenser #(
  parameter int WIDTH   = 32,
  parameter int INV_W   = 8,
  parameter int INIT_10 = 8,
  parameter int INIT_5  = 8,
  parameter int INIT_1  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] change_in,
  input  logic             change_valid,
  input  logic             coin_ack,
  input  logic             refill,
  input  logic [1:0]       refill_denom,
  input  logic [INV_W-1:0] refill_count,
  output logic [WIDTH-1:0] coin_out,
  output logic             coin_valid,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [WIDTH-1:0] remaining
);

  typedef enum logic [1:0] {IDLE, SELECT, EJECT, DONE} state_t;

  localparam logic [WIDTH-1:0] D10     = WIDTH'(10);
  localparam logic [WIDTH-1:0] D5      = WIDTH'(5);
  localparam logic [WIDTH-1:0] D1      = WIDTH'(1);
  localparam logic [INV_W-1:0] INV_MAX = '1;
  localparam logic [INV_W-1:0] INV_ONE = INV_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] coin_out_q, coin_out_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic             coin_valid_q, coin_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             short_q, short_d;
  logic [INV_W-1:0] inv10_q, inv10_d;
  logic [INV_W-1:0] inv5_q, inv5_d;
  logic [INV_W-1:0] inv1_q, inv1_d;

  function automatic logic [INV_W-1:0] sat_add(input logic [INV_W-1:0] a,
                                               input logic [INV_W-1:0] b);
    logic [INV_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[INV_W] ? INV_MAX : s[INV_W-1:0];
  endfunction

  always_comb begin
    state_d      = state_q;
    coin_out_d   = coin_out_q;
    remaining_d  = remaining_q;
    coin_valid_d = coin_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    short_d      = short_q;
    inv10_d      = inv10_q;
    inv5_d       = inv5_q;
    inv1_d       = inv1_q;

    case (state_q)
      IDLE: begin
        if (refill) begin
          case (refill_denom)
            2'd0:    inv1_d  = sat_add(inv1_q, refill_count);
            2'd1:    inv5_d  = sat_add(inv5_q, refill_count);
            2'd2:    inv10_d = sat_add(inv10_q, refill_count);
            default: ;
          endcase
        end
        if (change_valid) begin
          remaining_d = change_in;
          short_d     = 1'b0;
          busy_d      = 1'b1;
          state_d     = SELECT;
        end
      end

      SELECT: begin
        if (remaining_q == '0) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else if (remaining_q >= D10 && inv10_q != '0) begin
          coin_out_d   = D10;
          coin_valid_d = 1'b1;
          state_d      = EJECT;
        end else if (remaining_q >= D5 && inv5_q != '0) begin
          coin_out_d   = D5;
          coin_valid_d = 1'b1;
          state_d      = EJECT;
        end else if (inv1_q != '0) begin
          coin_out_d   = D1;
          coin_valid_d = 1'b1;
          state_d      = EJECT;
        end else begin
          short_d = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      EJECT: begin
        if (coin_ack) begin
          // coin_out never exceeds remaining, so this cannot wrap
          remaining_d  = remaining_q - coin_out_q;
          if (coin_out_q == D10)     inv10_d = inv10_q - INV_ONE;
          else if (coin_out_q == D5) inv5_d  = inv5_q - INV_ONE;
          else                       inv1_d  = inv1_q - INV_ONE;
          coin_valid_d = 1'b0;
          coin_out_d   = '0;
          state_d      = SELECT;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      coin_out_q   <= '0;
      remaining_q  <= '0;
      coin_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      short_q      <= 1'b0;
      inv10_q      <= INV_W'(INIT_10);
      inv5_q       <= INV_W'(INIT_5);
      inv1_q       <= INV_W'(INIT_1);
    end else begin
      state_q      <= state_d;
      coin_out_q   <= coin_out_d;
      remaining_q  <= remaining_d;
      coin_valid_q <= coin_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      short_q      <= short_d;
      inv10_q      <= inv10_d;
      inv5_q       <= inv5_d;
      inv1_q       <= inv1_d;
    end
  end

  assign coin_out   = coin_out_q;
  assign coin_valid = coin_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign short      = short_q;
  assign remaining  = remaining_q;

endmodule
